// File: rtl/vec_adder_pkg.sv
// Shared definitions for the vector adder: operation modes and default geometry.
package vec_adder_pkg;

  typedef enum logic [1:0] {
    MODE_ADD  = 2'd0,
    MODE_SUB  = 2'd1,
    MODE_ACC  = 2'd2,
    MODE_RSVD = 2'd3
  } mode_e;

  localparam int DEF_LANES     = 4;
  localparam int DEF_LANE_BITS = 16;

endpackage

// File: rtl/vec_adder_lane.sv
// One arithmetic lane: add/sub/accumulate with optional unsigned saturation,
// plus the lane's private accumulator register.
module vec_adder_lane
  import vec_adder_pkg::*;
#(
  parameter int LANE_BITS = DEF_LANE_BITS
) (
  input  logic                 clock_i,
  input  logic                 reset_i,
  input  logic                 fire_i,
  input  mode_e                mode_i,
  input  logic                 sat_i,
  input  logic                 acc_clear_i,
  input  logic [LANE_BITS-1:0] a_i,
  input  logic [LANE_BITS-1:0] b_i,
  output logic [LANE_BITS-1:0] res_o,
  output logic                 ovf_o
);

  localparam logic [LANE_BITS+1:0] MAX_SUM = {2'b00, {LANE_BITS{1'b1}}};

  logic [LANE_BITS-1:0] acc_q, acc_d;
  logic [LANE_BITS-1:0] acc_base;
  logic [LANE_BITS+1:0] sum;
  logic [LANE_BITS:0]   diff;

  // A clear coinciding with an accumulate makes that sum start from zero.
  always_comb begin
    acc_base = acc_clear_i ? '0 : acc_q;
    sum      = {2'b00, a_i} + {2'b00, b_i};
    if (mode_i == MODE_ACC) sum = sum + {2'b00, acc_base};
    diff     = {1'b0, a_i} - {1'b0, b_i};
    res_o    = sum[LANE_BITS-1:0];
    ovf_o    = (sum > MAX_SUM);
    if (mode_i == MODE_SUB) begin
      ovf_o = diff[LANE_BITS];
      res_o = diff[LANE_BITS-1:0];
      if (sat_i && ovf_o) res_o = '0;
    end else if (sat_i && ovf_o) begin
      res_o = '1;
    end
  end

  always_comb begin
    acc_d = acc_q;
    if (fire_i && (mode_i == MODE_ACC)) acc_d = res_o;
    else if (acc_clear_i)               acc_d = '0;
  end

  always_ff @(posedge clock_i) begin
    if (!reset_i) acc_q <= '0;
    else          acc_q <= acc_d;
  end

endmodule

// File: rtl/vec_adder.sv
// Multi-lane vector adder with joined A/B operand handshake and a
// 2-entry result FIFO supporting simultaneous push and pop.
module vec_adder
  import vec_adder_pkg::*;
#(
  parameter int LANES         = DEF_LANES,
  parameter int LANE_BITS     = DEF_LANE_BITS,
  parameter int MEM_DATA_BITS = LANES * LANE_BITS
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     a_valid,
  output logic                     a_ready,
  input  logic [MEM_DATA_BITS-1:0] a_data,
  input  logic                     b_valid,
  output logic                     b_ready,
  input  logic [MEM_DATA_BITS-1:0] b_data,
  input  logic [1:0]               mode,
  input  logic                     sat,
  input  logic                     acc_clear,
  output logic                     c_valid,
  input  logic                     c_ready,
  output logic [MEM_DATA_BITS-1:0] c_data,
  output logic [LANES-1:0]         c_ovf,
  output logic [31:0]              result_count
);

  logic [MEM_DATA_BITS-1:0] data_q [2];
  logic [LANES-1:0]         ovf_q  [2];
  logic [1:0]               count_q, count_d;
  logic                     rd_ptr_q, wr_ptr_q;
  logic                     en_q;
  logic [31:0]              result_count_q;

  logic                     space, fire, pop;
  logic [MEM_DATA_BITS-1:0] res_vec;
  logic [LANES-1:0]         ovf_vec;
  mode_e                    mode_s;

  assign mode_s = mode_e'(mode);

  // en_q keeps the operand side closed for the first cycle after reset release.
  assign c_valid = (count_q != 2'd0) && reset;
  assign pop     = c_valid && c_ready;
  assign space   = reset && en_q && ((count_q != 2'd2) || pop);
  assign fire    = a_valid && b_valid && space;
  assign a_ready = space && b_valid;
  assign b_ready = space && a_valid;

  assign c_data       = data_q[rd_ptr_q];
  assign c_ovf        = ovf_q[rd_ptr_q];
  assign result_count = result_count_q;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    vec_adder_lane #(
      .LANE_BITS (LANE_BITS)
    ) u_lane (
      .clock_i     (clock),
      .reset_i     (reset),
      .fire_i      (fire),
      .mode_i      (mode_s),
      .sat_i       (sat),
      .acc_clear_i (acc_clear),
      .a_i         (a_data[i*LANE_BITS +: LANE_BITS]),
      .b_i         (b_data[i*LANE_BITS +: LANE_BITS]),
      .res_o       (res_vec[i*LANE_BITS +: LANE_BITS]),
      .ovf_o       (ovf_vec[i])
    );
  end

  always_comb begin
    count_d = count_q;
    if (fire && !pop)      count_d = count_q + 2'd1;
    else if (!fire && pop) count_d = count_q - 2'd1;
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      count_q        <= '0;
      rd_ptr_q       <= 1'b0;
      wr_ptr_q       <= 1'b0;
      en_q           <= 1'b0;
      result_count_q <= '0;
    end else begin
      count_q <= count_d;
      en_q    <= 1'b1;
      if (fire) wr_ptr_q <= ~wr_ptr_q;
      if (pop) begin
        rd_ptr_q       <= ~rd_ptr_q;
        result_count_q <= result_count_q + 32'd1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (fire) begin
      data_q[wr_ptr_q] <= res_vec;
      ovf_q[wr_ptr_q]  <= ovf_vec;
    end
  end

endmodule

// File: tb/tb_vec_adder.sv
// Self-checking bench for vec_adder: directed cases plus random traffic
// against a queue-based reference model.
module tb_vec_adder;

  localparam int LANES = 4;
  localparam int LB    = 16;
  localparam int MDB   = LANES * LB;

  logic             clock = 1'b0;
  logic             reset;
  logic             a_valid, b_valid, a_ready, b_ready;
  logic [MDB-1:0]   a_data, b_data;
  logic [1:0]       mode;
  logic             sat, acc_clear;
  logic             c_valid, c_ready;
  logic [MDB-1:0]   c_data;
  logic [LANES-1:0] c_ovf;
  logic [31:0]      result_count;

  vec_adder #(.LANES(LANES), .LANE_BITS(LB), .MEM_DATA_BITS(MDB)) dut (
    .clock(clock), .reset(reset),
    .a_valid(a_valid), .a_ready(a_ready), .a_data(a_data),
    .b_valid(b_valid), .b_ready(b_ready), .b_data(b_data),
    .mode(mode), .sat(sat), .acc_clear(acc_clear),
    .c_valid(c_valid), .c_ready(c_ready), .c_data(c_data), .c_ovf(c_ovf),
    .result_count(result_count)
  );

  always #5 clock = ~clock;

  typedef struct { logic [MDB-1:0] d; logic [LANES-1:0] o; } res_t;

  res_t              exp_q[$];
  longint unsigned   acc_m [LANES];
  logic [31:0]       cnt_m;
  bit                en_m;
  bit                chk_en;
  int                errors;
  int                checks;

  task automatic check(input string tag, input logic [MDB-1:0] got, input logic [MDB-1:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Lane arithmetic computed with plain integers; updates acc_m on ACC.
  function automatic void ref_op(input logic [MDB-1:0] a, input logic [MDB-1:0] b,
                                 input logic [1:0] m, input bit s, input bit clr,
                                 output logic [MDB-1:0] r, output logic [LANES-1:0] o);
    longint unsigned mx, av, bv, sum, res;
    bit of;
    mx = 64'd1 << LB;
    r = '0;
    o = '0;
    for (int i = 0; i < LANES; i++) begin
      av = longint'(a[i*LB +: LB]);
      bv = longint'(b[i*LB +: LB]);
      if (m == 2'd1) begin
        of  = (av < bv);
        res = of ? (s ? 0 : av + mx - bv) : av - bv;
      end else begin
        sum = av + bv;
        if (m == 2'd2) sum = sum + (clr ? 0 : acc_m[i]);
        of  = (sum >= mx);
        res = of ? (s ? mx - 1 : sum % mx) : sum;
        if (m == 2'd2) acc_m[i] = res;
      end
      r[i*LB +: LB] = res[LB-1:0];
      o[i] = of;
    end
  endfunction

  task automatic step(input logic [MDB-1:0] a, input logic [MDB-1:0] b, input bit av, input bit bv,
                      input logic [1:0] m, input bit s, input bit clr, input bit crdy, input bit rst);
    bit exp_cv, exp_space, pop, fire;
    logic [MDB-1:0]   r;
    logic [LANES-1:0] o;
    a_data = a; b_data = b; a_valid = av; b_valid = bv;
    mode = m; sat = s; acc_clear = clr; c_ready = crdy; reset = rst;
    #1;
    exp_cv    = rst && (exp_q.size() > 0);
    exp_space = rst && en_m && ((exp_q.size() < 2) || (exp_cv && crdy));
    if (chk_en) begin
      check("c_valid", MDB'(c_valid), MDB'(exp_cv));
      if (exp_cv) begin
        check("c_data", c_data, exp_q[0].d);
        check("c_ovf", MDB'(c_ovf), MDB'(exp_q[0].o));
      end
      check("a_ready", MDB'(a_ready), MDB'(exp_space && bv));
      check("b_ready", MDB'(b_ready), MDB'(exp_space && av));
      check("result_count", MDB'(result_count), MDB'(cnt_m));
    end
    if (!rst) begin
      exp_q.delete();
      for (int i = 0; i < LANES; i++) acc_m[i] = 0;
      cnt_m = '0;
      en_m  = 1'b0;
    end else begin
      pop  = exp_cv && crdy;
      fire = av && bv && exp_space;
      r = '0;
      o = '0;
      if (fire) ref_op(a, b, m, s, clr, r, o);
      if (clr && !(fire && m == 2'd2))
        for (int i = 0; i < LANES; i++) acc_m[i] = 0;
      if (pop) begin
        void'(exp_q.pop_front());
        cnt_m = cnt_m + 32'd1;
      end
      if (fire) exp_q.push_back('{d: r, o: o});
      en_m = 1'b1;
    end
    @(posedge clock);
    #2;
  endtask

  task automatic expect_head(input string tag, input logic [MDB-1:0] d, input logic [LANES-1:0] o);
    check({tag, "_valid"}, MDB'(c_valid), MDB'(1'b1));
    check({tag, "_data"}, c_data, d);
    check({tag, "_ovf"}, MDB'(c_ovf), MDB'(o));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step('0, '0, 0, 0, 2'd0, 0, 0, 1, 1);
  endtask

  localparam logic [MDB-1:0] ONES  = 64'h0001_0001_0001_0001;
  localparam logic [MDB-1:0] TWOS  = 64'h0002_0002_0002_0002;

  initial begin
    logic [MDB-1:0] ra, rb;
    errors = 0; checks = 0; chk_en = 0; cnt_m = '0; en_m = 0;
    for (int i = 0; i < LANES; i++) acc_m[i] = 0;

    step('0, '0, 0, 0, 2'd0, 0, 0, 1, 0);
    chk_en = 1;
    step('0, '0, 1, 1, 2'd0, 0, 0, 1, 0);
    check("rst_c_valid", MDB'(c_valid), '0);
    check("rst_a_ready", MDB'(a_ready), '0);
    check("rst_count", MDB'(result_count), '0);
    step('0, '0, 1, 1, 2'd0, 0, 0, 1, 1);
    idle(2);

    // ADD wrap and saturate
    step(64'h0001_0002_FFFF_7FFF, 64'h0001_0002_0001_0001, 1, 1, 2'd0, 0, 0, 1, 1);
    expect_head("add_wrap", 64'h0002_0004_0000_8000, 4'b0010);
    step(64'h0001_0002_FFFF_7FFF, 64'h0001_0002_0001_0001, 1, 1, 2'd0, 1, 0, 1, 1);
    expect_head("add_sat", 64'h0002_0004_FFFF_8000, 4'b0010);
    // SUB underflow
    step(64'h0005_0005_0005_0005, 64'h0007_0007_0007_0007, 1, 1, 2'd1, 0, 0, 1, 1);
    expect_head("sub_wrap", 64'hFFFE_FFFE_FFFE_FFFE, 4'b1111);
    step(64'h0005_0005_0005_0005, 64'h0007_0007_0007_0007, 1, 1, 2'd1, 1, 0, 1, 1);
    expect_head("sub_sat", '0, 4'b1111);
    // reserved mode behaves as ADD
    step(64'h8000_0000_0010_0003, 64'h8000_0000_0020_0004, 1, 1, 2'd3, 0, 0, 1, 1);
    expect_head("rsvd_add", 64'h0000_0000_0030_0007, 4'b1000);
    idle(2);

    // Accumulate 3, 6, 9, then clear-with-fire gives 3
    step('0, '0, 0, 0, 2'd0, 0, 1, 1, 1);
    step(ONES, TWOS, 1, 1, 2'd2, 0, 0, 1, 1);
    expect_head("acc1", 64'h0003_0003_0003_0003, '0);
    step(ONES, TWOS, 1, 1, 2'd2, 0, 0, 1, 1);
    expect_head("acc2", 64'h0006_0006_0006_0006, '0);
    step(ONES, TWOS, 1, 1, 2'd2, 0, 0, 1, 1);
    expect_head("acc3", 64'h0009_0009_0009_0009, '0);
    step(ONES, TWOS, 1, 1, 2'd2, 0, 1, 1, 1);
    expect_head("acc_clr", 64'h0003_0003_0003_0003, '0);
    idle(2);

    // Backpressure: buffer fills with 2, then drains in order
    for (int i = 0; i < 5; i++)
      step(MDB'(i + 1), MDB'(16'h0100), 1, 1, 2'd0, 0, 0, 0, 1);
    check("bp_a_ready", MDB'(a_ready), '0);
    check("bp_b_ready", MDB'(b_ready), '0);
    expect_head("bp_head", 64'h0000_0000_0000_0101, '0);
    for (int i = 0; i < 4; i++)
      step(MDB'(i + 16), MDB'(16'h0200), 1, 1, 2'd0, 0, 0, 1, 1);
    idle(3);

    // Reset with buffered results and a pending ACC
    step(ONES, ONES, 1, 1, 2'd2, 0, 0, 0, 1);
    step(ONES, ONES, 1, 1, 2'd2, 0, 0, 0, 1);
    step(ONES, ONES, 1, 1, 2'd2, 0, 0, 0, 0);
    check("mid_rst_c_valid", MDB'(c_valid), '0);
    check("mid_rst_count", MDB'(result_count), '0);
    step(ONES, ONES, 1, 1, 2'd2, 0, 0, 1, 1);
    step(ONES, ONES, 1, 1, 2'd2, 0, 0, 1, 1);
    expect_head("post_rst_acc", TWOS, '0);
    idle(2);

    // Random traffic
    for (int n = 0; n < 400; n++) begin
      ra = {$urandom, $urandom};
      rb = {$urandom, $urandom};
      step(ra, rb, $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
           2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
           $urandom_range(0, 9) == 0, $urandom_range(0, 2) != 0,
           $urandom_range(0, 79) != 0);
    end
    idle(4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/vec_adder.md
VEC_ADDER -- requirements
Module: vec_adder

Interface
REQ-001 SHALL have parameter LANES, default 4, number of independent arithmetic lanes.
REQ-002 SHALL have parameter LANE_BITS, default 16, width of one lane.
REQ-003 SHALL have parameter MEM_DATA_BITS, default LANES*LANE_BITS, packed vector width; lane i occupies bits [i*LANE_BITS +: LANE_BITS].
REQ-004 SHALL have port: clock  input  1  single clock; all logic on rising edge.
REQ-005 SHALL have port: reset  input  1  synchronous, active-low reset (asserted when 0).
REQ-006 SHALL have port: a_valid  input  1  operand A offered.
REQ-007 SHALL have port: a_ready  output  1  operand A accepted this cycle when high with a_valid.
REQ-008 SHALL have port: a_data  input  MEM_DATA_BITS  operand A vector.
REQ-009 SHALL have ports: b_valid  input  1;  b_ready  output  1;  b_data  input  MEM_DATA_BITS. These are the operand B equivalents of a_valid, a_ready and a_data.
REQ-010 SHALL have port: mode  input  2  0=ADD, 1=SUB, 2=ACC, 3=reserved.
REQ-011 SHALL have port: sat  input  1  1=unsigned saturate, 0=wrap.
REQ-012 SHALL have port: acc_clear  input  1  zero all lane accumulators.
REQ-013 SHALL have port: c_valid  output  1  result available.
REQ-014 SHALL have port: c_ready  input  1  consumer accepts result.
REQ-015 SHALL have port: c_data  output  MEM_DATA_BITS  result vector.
REQ-016 SHALL have port: c_ovf  output  LANES  per-lane overflow/underflow flag, aligned with c_data.
REQ-017 SHALL have port: result_count  output  32  number of results accepted by the consumer, wrapping at 2^32.

Function
REQ-018 SHALL fire when a_valid & b_valid & space. space = output buffer (2 entries) not full, or full with c_valid & c_ready in the same cycle.
REQ-019 SHALL drive a_ready = space & b_valid and b_ready = space & a_valid, so A and B are always consumed together and never individually.
REQ-020 SHALL sample mode and sat only on a fire cycle.
REQ-021 SHALL write the result into the output buffer at the fire edge; c_valid rises the next cycle when the buffer was empty (latency 1).
REQ-022 SHALL compute, per lane in ADD mode, a+b; the ovf flag is the carry out of LANE_BITS; if sat=1 and ovf, the result is all ones; if sat=0, the result wraps modulo 2^LANE_BITS.
REQ-023 SHALL compute, per lane in SUB mode, a-b; the ovf flag is set when a<b; if sat=1 and ovf, the result is 0; if sat=0, the result wraps.
REQ-024 SHALL compute, per lane in ACC mode, acc+a+b using the ADD overflow/saturation rule over the full 3-operand sum; the lane result is written to both the buffer and acc.
REQ-025 SHALL treat mode=3 as ADD.
REQ-026 SHALL make acc_clear zero every acc at the next edge. When acc_clear coincides with an ACC fire, acc is taken as 0 for that sum and acc ends up holding a+b (sat/wrap applied).
REQ-027 SHALL leave acc unchanged on ADD and SUB fires.
REQ-028 SHALL keep the output buffer FIFO-ordered; c_data and c_ovf hold stable while c_valid & !c_ready.
REQ-029 SHALL support a simultaneous push and pop on a full buffer, giving full throughput of 1 result/cycle with c_ready held high.
REQ-030 SHALL increment result_count on each c_valid & c_ready.

Reset
REQ-031 SHALL, while reset=0 at an edge, empty the buffer, zero all acc, and zero result_count.
REQ-032 SHALL hold c_valid=0, a_ready=0 and b_ready=0 during reset and in the first cycle after release.
REQ-033 SHALL discard any in-flight or buffered result when reset is asserted mid-operation, with no partial output.

Structure
REQ-034 SHALL place the mode enum (ADD/SUB/ACC/RSVD) and the default LANES/LANE_BITS constants in shared package vec_adder_pkg.
REQ-035 SHALL implement per-lane arithmetic, saturation and the acc register in sub-module vec_adder_lane, instantiated LANES times via generate.
REQ-036 SHALL keep the 2-entry output buffer and handshake logic in vec_adder.

Verification (LANES=4, LANE_BITS=16)
REQ-037 SHALL verify that ADD with a=0x0001_0002_FFFF_7FFF, b=0x0001_0002_0001_0001, sat=0 gives c=0x0002_0004_0000_8000, c_ovf=0b0010, one cycle after fire.
REQ-038 SHALL verify that the same ADD with sat=1 gives c=0x0002_0004_FFFF_8000, c_ovf=0b0010.
REQ-039 SHALL verify that SUB with a=0x0005 and b=0x0007 in every lane gives 0xFFFE per lane when sat=0 and 0x0000 per lane when sat=1, with c_ovf=0b1111 in both cases.
REQ-040 SHALL verify that three ACC fires of a=1, b=2 give 3, 6, 9, and that acc_clear on the fourth ACC fire gives 3.
REQ-041 SHALL verify that holding c_ready=0 for 5 cycles with continuous valid operands fills the buffer, accepts exactly 2 results, and drops a_ready/b_ready to 0. On releasing c_ready, 1 result/cycle resumes in order and result_count increments per pop.
REQ-042 SHALL verify that asserting reset=0 with 2 buffered results and a valid ACC input gives c_valid=0 and result_count=0 after reset; after release, an ACC of a=1, b=1 gives 2.
